// File: rtl/truco_placar.sv
// Truco scoreboard: scores each trick from the comparator, resolves best-of-three hands and accumulates game score.
// Optional stakes raising (TrucoReq / HandValue) is enabled by defining TRUCO_STAKES_EN.
module truco_placar #(
  parameter int WIN_SCORE = 12,
  parameter int SCORE_W   = 4
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic [2:0]         PS1,
  input  logic [2:0]         PS2,
  input  logic               End,
  input  logic               NewGame,
`ifdef TRUCO_STAKES_EN
  input  logic               TrucoReq,
  output logic [3:0]         HandValue,
`endif
  output logic [SCORE_W-1:0] Score1,
  output logic [SCORE_W-1:0] Score2,
  output logic [1:0]         Trick,
  output logic               HandDone,
  output logic [1:0]         HandWinner,
  output logic               GameOver,
  output logic [1:0]         GameWinner
);

  typedef enum logic [2:0] {
    S_T1      = 3'd0,
    S_T2      = 3'd1,
    S_T3      = 3'd2,
    S_RESOLVE = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic               end_q;
  logic [1:0]         r1_q;
  logic [1:0]         trick_q;
  logic [1:0]         hand_winner_q;
  logic [SCORE_W-1:0] score_q [2];
  logic [3:0]         hand_value;

  logic               clear;
  logic               evt;
  logic [1:0]         cur_res;
  logic               resolve;
  logic [1:0]         decided;
  logic               any_win;

  assign clear   = ~Clr | NewGame;
  assign evt     = End & ~end_q;
  assign cur_res = (PS1 > PS2) ? RES_P1 : ((PS2 > PS1) ? RES_P2 : RES_TIE);
  assign any_win = (score_q[0] == WIN_VAL) || (score_q[1] == WIN_VAL);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [3:0] v);
    logic [SCORE_W+3:0] sum;
    sum = (SCORE_W+4)'(s) + (SCORE_W+4)'(v);
    if (sum >= (SCORE_W+4)'(WIN_SCORE)) return WIN_VAL;
    return sum[SCORE_W-1:0];
  endfunction

  // State register
  always_ff @(posedge Clk) begin
    if (clear) state_q <= S_T1;
    else       state_q <= state_d;
  end

  // Next-state and hand decision
  always_comb begin
    state_d = state_q;
    resolve = 1'b0;
    decided = RES_TIE;
    case (state_q)
      S_T1: begin
        if (evt) state_d = S_T2;
      end
      S_T2: begin
        if (evt) begin
          if (r1_q != RES_TIE && (cur_res == r1_q || cur_res == RES_TIE)) begin
            resolve = 1'b1;
            decided = r1_q;
          end else if (r1_q == RES_TIE && cur_res != RES_TIE) begin
            resolve = 1'b1;
            decided = cur_res;
          end else begin
            state_d = S_T3;
          end
          if (resolve) state_d = S_RESOLVE;
        end
      end
      S_T3: begin
        // Reaching T3 means a split or a double tie; a tied third trick falls back to r1.
        if (evt) begin
          resolve = 1'b1;
          decided = (cur_res != RES_TIE) ? cur_res : r1_q;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: state_d = any_win ? S_OVER : S_T1;
      S_OVER:    state_d = S_OVER;
      default:   state_d = S_T1;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    HandDone   = 1'b0;
    GameOver   = 1'b0;
    GameWinner = 2'b00;
    case (state_q)
      S_RESOLVE: HandDone = 1'b1;
      S_OVER: begin
        GameOver   = 1'b1;
        GameWinner = (score_q[0] == WIN_VAL) ? RES_P1 : RES_P2;
      end
      default: ;
    endcase
  end

  // Hand bookkeeping; results become visible in the RESOLVE cycle itself.
  always_ff @(posedge Clk) begin
    if (clear) begin
      end_q         <= 1'b0;
      r1_q          <= RES_TIE;
      trick_q       <= 2'd0;
      hand_winner_q <= RES_TIE;
    end else begin
      end_q <= End;
      if (state_q == S_T1 && evt) begin
        r1_q    <= cur_res;
        trick_q <= 2'd1;
      end
      if (state_q == S_T2 && evt && !resolve) trick_q <= 2'd2;
      if (resolve) begin
        trick_q       <= 2'd0;
        hand_winner_q <= decided;
      end
    end
  end

`ifdef TRUCO_STAKES_EN
  logic [3:0] hand_value_q;

  always_ff @(posedge Clk) begin
    if (clear) begin
      hand_value_q <= 4'd1;
    end else if (state_q == S_RESOLVE) begin
      hand_value_q <= 4'd1;
    end else if (TrucoReq && (state_q == S_T1 || state_q == S_T2 || state_q == S_T3)) begin
      case (hand_value_q)
        4'd1:    hand_value_q <= 4'd3;
        4'd3:    hand_value_q <= 4'd6;
        4'd6:    hand_value_q <= 4'd9;
        default: hand_value_q <= 4'd12;
      endcase
    end
  end

  assign hand_value = hand_value_q;
  assign HandValue  = hand_value_q;
`else
  assign hand_value = 4'd1;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_score
      always_ff @(posedge Clk) begin
        if (clear)                      score_q[gi] <= '0;
        else if (resolve && decided[gi]) score_q[gi] <= sat_add(score_q[gi], hand_value);
      end
    end
  endgenerate

  assign Score1     = score_q[0];
  assign Score2     = score_q[1];
  assign Trick      = trick_q;
  assign HandWinner = hand_winner_q;

endmodule

// File: tb/tb_truco_placar.sv
// Directed bench for truco_placar: trick scoring, hand resolution, game end and edge-only End counting.
module tb_truco_placar;

  logic       Clk = 1'b0;
  logic       Clr;
  logic [2:0] PS1, PS2;
  logic       End;
  logic       NewGame;
  logic [3:0] Score1, Score2;
  logic [1:0] Trick;
  logic       HandDone;
  logic [1:0] HandWinner;
  logic       GameOver;
  logic [1:0] GameWinner;

  int checks   = 0;
  int failures = 0;

  truco_placar #(.WIN_SCORE(12), .SCORE_W(4)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .PS1        (PS1),
    .PS2        (PS2),
    .End        (End),
    .NewGame    (NewGame),
    .Score1     (Score1),
    .Score2     (Score2),
    .Trick      (Trick),
    .HandDone   (HandDone),
    .HandWinner (HandWinner),
    .GameOver   (GameOver),
    .GameWinner (GameWinner)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Raise End with the given cards; returns at the next falling edge, one rising edge later.
  task automatic up(input logic [2:0] a, input logic [2:0] b);
    PS1 = a;
    PS2 = b;
    End = 1'b1;
    @(negedge Clk);
  endtask

  task automatic down();
    End = 1'b0;
    @(negedge Clk);
  endtask

  task automatic play(input logic [2:0] a, input logic [2:0] b);
    up(a, b);
    down();
  endtask

  initial begin
    Clr = 1'b0; NewGame = 1'b0; End = 1'b0; PS1 = 3'd5; PS2 = 3'd1;
    @(negedge Clk);
    $display("step reset with End toggling");
    End = 1'b1;
    @(negedge Clk);
    check("rst_handdone_a", {7'd0, HandDone}, 8'd0);
    check("rst_trick_a", {6'd0, Trick}, 8'd0);
    End = 1'b0;
    @(negedge Clk);
    check("rst_handdone_b", {7'd0, HandDone}, 8'd0);
    Clr = 1'b1;
    @(negedge Clk);
    check("rst_score1", {4'd0, Score1}, 8'd0);
    check("rst_score2", {4'd0, Score2}, 8'd0);
    check("rst_trick", {6'd0, Trick}, 8'd0);
    check("rst_gameover", {7'd0, GameOver}, 8'd0);
    check("rst_handwinner", {6'd0, HandWinner}, 8'd0);

    $display("step P1 two straight (5,2),(6,1)");
    up(3'd5, 3'd2);
    check("p1s_trick1", {6'd0, Trick}, 8'd1);
    check("p1s_nodone", {7'd0, HandDone}, 8'd0);
    down();
    up(3'd6, 3'd1);
    check("p1s_done", {7'd0, HandDone}, 8'd1);
    check("p1s_winner", {6'd0, HandWinner}, 8'd1);
    check("p1s_score1", {4'd0, Score1}, 8'd1);
    check("p1s_trick0", {6'd0, Trick}, 8'd0);
    down();
    check("p1s_done_pulse", {7'd0, HandDone}, 8'd0);
    check("p1s_winner_held", {6'd0, HandWinner}, 8'd1);

    $display("step tie then win (3,3),(2,7)");
    up(3'd3, 3'd3);
    check("tw_nodone", {7'd0, HandDone}, 8'd0);
    down();
    up(3'd2, 3'd7);
    check("tw_done", {7'd0, HandDone}, 8'd1);
    check("tw_winner", {6'd0, HandWinner}, 8'd2);
    check("tw_score2", {4'd0, Score2}, 8'd1);
    check("tw_score1", {4'd0, Score1}, 8'd1);
    down();

    $display("step split then tie (7,1),(0,4),(5,5)");
    play(3'd7, 3'd1);
    up(3'd0, 3'd4);
    check("st_trick2", {6'd0, Trick}, 8'd2);
    check("st_nodone", {7'd0, HandDone}, 8'd0);
    down();
    up(3'd5, 3'd5);
    check("st_done", {7'd0, HandDone}, 8'd1);
    check("st_winner", {6'd0, HandWinner}, 8'd1);
    check("st_score1", {4'd0, Score1}, 8'd2);
    down();

    $display("step triple tie (4,4)x3");
    play(3'd4, 3'd4);
    play(3'd4, 3'd4);
    up(3'd4, 3'd4);
    check("tt_done", {7'd0, HandDone}, 8'd1);
    check("tt_winner", {6'd0, HandWinner}, 8'd0);
    check("tt_score1", {4'd0, Score1}, 8'd2);
    check("tt_score2", {4'd0, Score2}, 8'd1);
    down();

    $display("step split then P2 third (7,1),(0,4),(2,6)");
    play(3'd7, 3'd1);
    play(3'd0, 3'd4);
    up(3'd2, 3'd6);
    check("sp_done", {7'd0, HandDone}, 8'd1);
    check("sp_winner", {6'd0, HandWinner}, 8'd2);
    check("sp_score2", {4'd0, Score2}, 8'd2);
    down();

    $display("step End held high 10 cycles");
    PS1 = 3'd6; PS2 = 3'd0; End = 1'b1;
    repeat (10) @(negedge Clk);
    check("held_trick", {6'd0, Trick}, 8'd1);
    check("held_score1", {4'd0, Score1}, 8'd2);
    down();
    up(3'd6, 3'd0);
    check("held_done", {7'd0, HandDone}, 8'd1);
    check("held_score1_after", {4'd0, Score1}, 8'd3);
    down();

    $display("step P1 hands to game end");
    for (int h = 4; h <= 12; h++) begin
      play(3'd5, 3'd2);
      up(3'd6, 3'd1);
      check($sformatf("run_score1_h%0d", h), {4'd0, Score1}, 8'(h));
      down();
    end
    check("go_gameover", {7'd0, GameOver}, 8'd1);
    check("go_gamewinner", {6'd0, GameWinner}, 8'd1);

    $display("step edges after game over");
    play(3'd0, 3'd7);
    play(3'd0, 3'd7);
    play(3'd0, 3'd7);
    check("go_score1_frozen", {4'd0, Score1}, 8'd12);
    check("go_score2_frozen", {4'd0, Score2}, 8'd2);
    check("go_trick", {6'd0, Trick}, 8'd0);
    check("go_still_over", {7'd0, GameOver}, 8'd1);

    $display("step NewGame");
    NewGame = 1'b1;
    @(negedge Clk);
    NewGame = 1'b0;
    check("ng_score1", {4'd0, Score1}, 8'd0);
    check("ng_score2", {4'd0, Score2}, 8'd0);
    check("ng_gameover", {7'd0, GameOver}, 8'd0);
    check("ng_gamewinner", {6'd0, GameWinner}, 8'd0);
    check("ng_handwinner", {6'd0, HandWinner}, 8'd0);
    check("ng_trick", {6'd0, Trick}, 8'd0);

    $display("step hand after NewGame (1,6),(2,5)");
    play(3'd1, 3'd6);
    up(3'd2, 3'd5);
    check("ng_hand_winner", {6'd0, HandWinner}, 8'd2);
    check("ng_hand_score2", {4'd0, Score2}, 8'd1);
    down();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
